// File: rtl/bus_timeout_handler_if.sv
// Bus snoop and injected-response bundle between a bus master and bus_timeout_handler.
// The handler observes the request/response handshake and drives the abort_* response.
interface bus_timeout_handler_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  bus_req_i;
    logic                  bus_gnt_i;
    logic [BUS_WIDTH-1:0]  bus_addr_i;
    logic                  bus_we_i;
    logic                  bus_rvalid_i;
    logic                  resp_ready_i;
    logic                  abort_rvalid_o;
    logic                  abort_err_o;
    logic [DATA_WIDTH-1:0] abort_rdata_o;

    modport slave (
        input  bus_req_i,
        input  bus_gnt_i,
        input  bus_addr_i,
        input  bus_we_i,
        input  bus_rvalid_i,
        input  resp_ready_i,
        output abort_rvalid_o,
        output abort_err_o,
        output abort_rdata_o
    );

    modport master (
        output bus_req_i,
        output bus_gnt_i,
        output bus_addr_i,
        output bus_we_i,
        output bus_rvalid_i,
        output resp_ready_i,
        input  abort_rvalid_o,
        input  abort_err_o,
        input  abort_rdata_o
    );
endinterface

// File: rtl/bus_timeout_handler.sv
// Turns a watchdog timeout into an error response, an interconnect flush and a sticky fault record.
// Optional BUS_TIMEOUT_HANDLER_OVERFLOW_EN adds fault_overflow_o and keeps the first unacknowledged fault.
module bus_timeout_handler #(
    parameter int                    BUS_WIDTH    = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA    = 32'hDEAD_BEEF,
    parameter int                    FLUSH_CYCLES = 4,
    parameter int                    CNT_WIDTH    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bus_timeout_handler_if.slave bus,
    input  logic                 watchdog_irq_i,
    output logic                 slave_flush_o,
    output logic                 late_rsp_drop_o,
    output logic [BUS_WIDTH-1:0] fault_addr_o,
    output logic                 fault_we_o,
    output logic [CNT_WIDTH-1:0] fault_count_o,
    output logic                 irq_o,
`ifdef BUS_TIMEOUT_HANDLER_OVERFLOW_EN
    output logic                 fault_overflow_o,
`endif
    input  logic                 irq_ack_i
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRACK = 3'd1,
        ST_ABORT = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [7:0]           FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic                   irq_q_r;
    logic [BUS_WIDTH-1:0]   pend_addr_r;
    logic                   pend_we_r;
    logic [7:0]             flush_cnt_r;
    logic                   slave_flush_r;
    logic                   late_drop_r;
    logic [BUS_WIDTH-1:0]   fault_addr_r;
    logic                   fault_we_r;
    logic [CNT_WIDTH-1:0]   fault_count_r;
    logic                   irq_r;
    logic                   ovf_r;

    logic                   accept_s;
    logic                   irq_rise_s;
    logic                   capture_s;
    logic                   fault_s;
    logic                   late_s;
    logic                   flush_last_s;
    logic                   keep_first_s;

    assign accept_s     = bus.bus_req_i & bus.bus_gnt_i;
    assign irq_rise_s   = watchdog_irq_i & ~irq_q_r;
    assign capture_s    = accept_s & ((state_r == ST_IDLE) |
                                      ((state_r == ST_TRACK) & bus.bus_rvalid_i));
    assign fault_s      = (state_r == ST_ABORT) & bus.resp_ready_i;
    assign late_s       = bus.bus_rvalid_i & ((state_r == ST_ABORT) |
                                              (state_r == ST_FLUSH) |
                                              (state_r == ST_DRAIN));
    assign flush_last_s = (state_r == ST_FLUSH) & (flush_cnt_r == FLUSH_LAST);

`ifdef BUS_TIMEOUT_HANDLER_OVERFLOW_EN
    // A fault arriving while software has not yet acknowledged the previous one keeps the first record.
    assign keep_first_s     = irq_r;
    assign fault_overflow_o = ovf_r;
`else
    assign keep_first_s     = 1'b0;
`endif

    // Next-state decode; a response in the same cycle as the irq edge completes normally.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_TRACK;
                else          state_nxt_s = ST_IDLE;
            end
            ST_TRACK: begin
                if (bus.bus_rvalid_i) begin
                    if (accept_s) state_nxt_s = ST_TRACK;
                    else          state_nxt_s = ST_IDLE;
                end else if (irq_rise_s) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    state_nxt_s = ST_TRACK;
                end
            end
            ST_ABORT: begin
                if (bus.resp_ready_i) state_nxt_s = ST_FLUSH;
                else                  state_nxt_s = ST_ABORT;
            end
            ST_FLUSH: begin
                if (flush_last_s) state_nxt_s = ST_DRAIN;
                else              state_nxt_s = ST_FLUSH;
            end
            ST_DRAIN: begin
                if (!watchdog_irq_i) state_nxt_s = ST_IDLE;
                else                 state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Injected response decodes straight from the state so it holds until the master takes it.
    always_comb begin
        bus.abort_rvalid_o = 1'b0;
        bus.abort_err_o    = 1'b0;
        bus.abort_rdata_o  = '0;
        if (state_r == ST_ABORT) begin
            bus.abort_rvalid_o = 1'b1;
            bus.abort_err_o    = 1'b1;
            bus.abort_rdata_o  = ERR_RDATA;
        end else begin
            bus.abort_rvalid_o = 1'b0;
            bus.abort_err_o    = 1'b0;
            bus.abort_rdata_o  = '0;
        end
    end

    // State, watchdog edge history, flush timer and the per-cycle flush/drop outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= ST_IDLE;
            irq_q_r       <= 1'b0;
            flush_cnt_r   <= 8'd0;
            slave_flush_r <= 1'b0;
            late_drop_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            irq_q_r       <= watchdog_irq_i;
            flush_cnt_r   <= (state_r == ST_FLUSH) ? flush_cnt_r + 8'd1 : 8'd0;
            slave_flush_r <= (state_nxt_s == ST_FLUSH);
            late_drop_r   <= late_s;
        end
    end

    // Pending transaction captured on every tracked accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_addr_r <= '0;
            pend_we_r   <= 1'b0;
        end else if (capture_s) begin
            pend_addr_r <= bus.bus_addr_i;
            pend_we_r   <= bus.bus_we_i;
        end
    end

    // Fault record and saturating counter, updated on the abort handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_addr_r  <= '0;
            fault_we_r    <= 1'b0;
            fault_count_r <= '0;
        end else if (fault_s) begin
            if (!keep_first_s) begin
                fault_addr_r <= pend_addr_r;
                fault_we_r   <= pend_we_r;
            end
            if (fault_count_r != CNT_MAX) begin
                fault_count_r <= fault_count_r + CNT_WIDTH'(1);
            end
        end
    end

    // Sticky interrupt and overflow flags; a new fault wins over a coincident acknowledge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            if (fault_s)        irq_r <= 1'b1;
            else if (irq_ack_i) irq_r <= 1'b0;
            if (fault_s && irq_r) ovf_r <= 1'b1;
            else if (irq_ack_i)   ovf_r <= 1'b0;
        end
    end

    assign slave_flush_o   = slave_flush_r;
    assign late_rsp_drop_o = late_drop_r;
    assign fault_addr_o    = fault_addr_r;
    assign fault_we_o      = fault_we_r;
    assign fault_count_o   = fault_count_r;
    assign irq_o           = irq_r;

`ifndef BUS_TIMEOUT_HANDLER_OVERFLOW_EN
    logic unused_ovf_s;
    assign unused_ovf_s = ovf_r;
`endif

endmodule

// File: tb/tb_bus_timeout_handler.sv
// Scenario bench for bus_timeout_handler: expected fault records are queued when a timeout is
// provoked and popped when the handler publishes the fault after the abort handshake.
module tb_bus_timeout_handler;
    localparam int          FC      = 4;
    localparam logic [31:0] ERR_EXP = 32'hDEAD_BEEF;
    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_TRACK = 3'd1;
    localparam logic [2:0]  S_DRAIN = 3'd4;
`ifdef BUS_TIMEOUT_HANDLER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  cnt;
    } fault_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wd_irq;
    logic        irq_ack;
    logic        slave_flush;
    logic        late_drop;
    logic [31:0] fault_addr;
    logic        fault_we;
    logic [7:0]  fault_count;
    logic        irq;
    logic        ovf;
    logic [2:0]  st;

    fault_exp_t  sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_cnt;
    logic        m_irq;
    logic        m_ovf;
    logic [31:0] m_addr;
    logic        m_we;

    bus_timeout_handler_if bif ();

    bus_timeout_handler dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus             (bif),
        .watchdog_irq_i  (wd_irq),
        .slave_flush_o   (slave_flush),
        .late_rsp_drop_o (late_drop),
        .fault_addr_o    (fault_addr),
        .fault_we_o      (fault_we),
        .fault_count_o   (fault_count),
        .irq_o           (irq),
`ifdef BUS_TIMEOUT_HANDLER_OVERFLOW_EN
        .fault_overflow_o(ovf),
`endif
        .irq_ack_i       (irq_ack)
    );

`ifndef BUS_TIMEOUT_HANDLER_OVERFLOW_EN
    assign ovf = 1'b0;
`endif
    assign st = dut.state_r;

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_txn(input logic [31:0] addr, input logic we);
        bif.bus_req_i  = 1'b1;
        bif.bus_gnt_i  = 1'b1;
        bif.bus_addr_i = addr;
        bif.bus_we_i   = we;
        cyc();
        bif.bus_req_i  = 1'b0;
        bif.bus_gnt_i  = 1'b0;
    endtask

    task automatic ack_irq();
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_irq: irq_o=%0b expected 0", irq); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ack_ovf: overflow=%0b expected 0", ovf); end
        m_irq = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Assumes a transaction for addr/we is outstanding (TRACK) and the watchdog is low.
    task automatic run_fault(input logic [31:0] addr, input logic we, input int rdelay,
                             input bit ack_with_set, input bit late);
        fault_exp_t e;
        fault_exp_t got;
        bit         seen;
        bit         keep;
        int         n;
        int         drops;
        keep   = OVF_EN && m_irq;
        m_cnt  = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
        e.addr = keep ? m_addr : addr;
        e.we   = keep ? m_we : we;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        wd_irq = 1'b1;
        cyc();
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (bif.abort_rvalid_o === 1'b1) seen = 1'b1;
            else cyc();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_start: abort_rvalid_o=%0b expected 1 within 4 cycles", bif.abort_rvalid_o);
            void'(sb_q.pop_back());
            wd_irq = 1'b0;
            cyc(12);
            return;
        end
        for (int i = 0; i <= rdelay; i++) begin
            checks++; if (bif.abort_rvalid_o !== 1'b1) begin errors++; $display("FAIL abort_hold: rvalid=%0b expected 1", bif.abort_rvalid_o); end
            checks++; if (bif.abort_err_o !== 1'b1) begin errors++; $display("FAIL abort_err: err=%0b expected 1", bif.abort_err_o); end
            checks++; if (bif.abort_rdata_o !== ERR_EXP) begin errors++; $display("FAIL abort_rdata: rdata=%0h expected %0h", bif.abort_rdata_o, ERR_EXP); end
            if (i < rdelay) cyc();
        end
        bif.resp_ready_i = 1'b1;
        irq_ack          = ack_with_set;
        cyc();
        bif.resp_ready_i = 1'b0;
        irq_ack          = 1'b0;
        m_ovf  = keep ? 1'b1 : (ack_with_set ? 1'b0 : m_ovf);
        m_irq  = 1'b1;
        m_addr = e.addr;
        m_we   = e.we;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: queue size 0 expected 1");
        end else begin
            got = sb_q.pop_front();
            checks++; if (fault_addr !== got.addr) begin errors++; $display("FAIL fault_addr: got %0h expected %0h", fault_addr, got.addr); end
            checks++; if (fault_we !== got.we) begin errors++; $display("FAIL fault_we: got %0b expected %0b", fault_we, got.we); end
            checks++; if (fault_count !== got.cnt) begin errors++; $display("FAIL fault_count: got %0d expected %0d", fault_count, got.cnt); end
        end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: irq_o=%0b expected 1", irq); end
        checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL overflow: got %0b expected %0b", ovf, m_ovf); end
        checks++; if (bif.abort_rvalid_o !== 1'b0) begin errors++; $display("FAIL abort_end: rvalid=%0b expected 0", bif.abort_rvalid_o); end
        n     = 0;
        drops = 0;
        while (slave_flush === 1'b1 && n < 20) begin
            n++;
            bif.bus_rvalid_i = (late && n == 2);
            cyc();
            drops += int'(late_drop);
        end
        bif.bus_rvalid_i = 1'b0;
        checks++; if (n != FC) begin errors++; $display("FAIL flush_len: got %0d cycles expected %0d", n, FC); end
        checks++; if (drops != (late ? 1 : 0)) begin errors++; $display("FAIL late_drop: got %0d pulses expected %0d", drops, late ? 1 : 0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (st !== S_DRAIN) begin errors++; $display("FAIL drain_hold: state=%0d expected %0d", st, S_DRAIN); end
            checks++; if (bif.abort_rvalid_o !== 1'b0) begin errors++; $display("FAIL retrigger: rvalid=%0b expected 0", bif.abort_rvalid_o); end
            cyc();
        end
        wd_irq = 1'b0;
        cyc();
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL drain_exit: state=%0d expected %0d", st, S_IDLE); end
    endtask

    task automatic test_reset();
        rst = 1'b1; wd_irq = 1'b0; irq_ack = 1'b0;
        bif.bus_req_i = 1'b0; bif.bus_gnt_i = 1'b0; bif.bus_addr_i = '0; bif.bus_we_i = 1'b0;
        bif.bus_rvalid_i = 1'b0; bif.resp_ready_i = 1'b0;
        m_cnt = 8'd0; m_irq = 1'b0; m_ovf = 1'b0; m_addr = '0; m_we = 1'b0;
        cyc(3);
        checks++; if (bif.abort_rvalid_o !== 1'b0 || bif.abort_err_o !== 1'b0 || bif.abort_rdata_o !== 32'h0)
            begin errors++; $display("FAIL reset_abort: rvalid=%0b err=%0b rdata=%0h expected 0", bif.abort_rvalid_o, bif.abort_err_o, bif.abort_rdata_o); end
        checks++; if (slave_flush !== 1'b0 || late_drop !== 1'b0)
            begin errors++; $display("FAIL reset_pulses: flush=%0b drop=%0b expected 0", slave_flush, late_drop); end
        checks++; if (fault_addr !== 32'h0 || fault_we !== 1'b0 || fault_count !== 8'd0)
            begin errors++; $display("FAIL reset_fault: addr=%0h we=%0b cnt=%0d expected 0", fault_addr, fault_we, fault_count); end
        checks++; if (irq !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%0b ovf=%0b expected 0", irq, ovf); end
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL reset_state: state=%0d expected %0d", st, S_IDLE); end
        rst = 1'b0;
        wd_irq = 1'b1;
        cyc(2);
        checks++; if (bif.abort_rvalid_o !== 1'b0 || st !== S_IDLE) begin errors++; $display("FAIL idle_ignore: rvalid=%0b state=%0d expected 0/0", bif.abort_rvalid_o, st); end
        wd_irq = 1'b0;
        cyc();
    endtask

    task automatic test_normal();
        start_txn(32'h0000_1000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (bif.abort_rvalid_o !== 1'b0 || st !== S_TRACK) begin errors++; $display("FAIL normal_track: rvalid=%0b state=%0d expected 0/1", bif.abort_rvalid_o, st); end
            cyc();
        end
        bif.bus_rvalid_i = 1'b1;
        cyc();
        bif.bus_rvalid_i = 1'b0;
        checks++; if (st !== S_IDLE) begin errors++; $display("FAIL normal_done: state=%0d expected %0d", st, S_IDLE); end
        checks++; if (irq !== 1'b0 || fault_count !== 8'd0 || late_drop !== 1'b0)
            begin errors++; $display("FAIL normal_side: irq=%0b cnt=%0d drop=%0b expected 0", irq, fault_count, late_drop); end
    endtask

    task automatic test_race();
        start_txn(32'h0000_8000, 1'b0);
        bif.bus_rvalid_i = 1'b1;
        wd_irq = 1'b1;
        cyc();
        bif.bus_rvalid_i = 1'b0;
        checks++; if (st !== S_IDLE || bif.abort_rvalid_o !== 1'b0) begin errors++; $display("FAIL race: state=%0d rvalid=%0b expected 0/0", st, bif.abort_rvalid_o); end
        start_txn(32'h0000_8004, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++; if (st !== S_TRACK || bif.abort_rvalid_o !== 1'b0) begin errors++; $display("FAIL level_entry: state=%0d rvalid=%0b expected 1/0", st, bif.abort_rvalid_o); end
            cyc();
        end
        bif.bus_rvalid_i = 1'b1;
        cyc();
        bif.bus_rvalid_i = 1'b0;
        wd_irq = 1'b0;
        cyc();
        checks++; if (st !== S_IDLE || fault_count !== 8'd0) begin errors++; $display("FAIL race_end: state=%0d cnt=%0d expected 0/0", st, fault_count); end
    endtask

    task automatic test_timeout_read();
        start_txn(32'h2000_0040, 1'b0);
        run_fault(32'h2000_0040, 1'b0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_ack_race();
        ack_irq();
        start_txn(32'h6000_0010, 1'b0);
        run_fault(32'h6000_0010, 1'b0, 0, 1'b0, 1'b0);
        start_txn(32'h7000_0020, 1'b1);
        run_fault(32'h7000_0020, 1'b1, 1, 1'b1, 1'b0);
    endtask

    task automatic test_late_and_guard();
        ack_irq();
        start_txn(32'h5000_0000, 1'b1);
        run_fault(32'h5000_0000, 1'b1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        ack_irq();
        start_txn(32'h0000_3000, 1'b0);
        bif.bus_rvalid_i = 1'b1;
        start_txn(32'h0000_4000, 1'b1);
        bif.bus_rvalid_i = 1'b0;
        checks++; if (st !== S_TRACK) begin errors++; $display("FAIL b2b_track: state=%0d expected %0d", st, S_TRACK); end
        run_fault(32'h0000_4000, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        logic [31:0] a;
        logic        w;
        ack_irq();
        for (int i = 0; i < 256; i++) begin
            a = 32'h0001_0000 + 32'(i * 4);
            w = i[0];
            start_txn(a, w);
            run_fault(a, w, 0, 1'b0, 1'b0);
        end
        checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL saturate: cnt=%0d expected 255", fault_count); end
    endtask

    task automatic test_reset_mid_flush();
        bit seen;
        start_txn(32'h0000_9000, 1'b0);
        wd_irq = 1'b1;
        cyc();
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (bif.abort_rvalid_o === 1'b1) seen = 1'b1;
            else cyc();
        end
        bif.resp_ready_i = 1'b1;
        cyc();
        bif.resp_ready_i = 1'b0;
        cyc();
        checks++; if (slave_flush !== 1'b1) begin errors++; $display("FAIL mid_flush: flush=%0b expected 1", slave_flush); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wd_irq = 1'b0;
        checks++; if (slave_flush !== 1'b0 || irq !== 1'b0 || fault_count !== 8'd0 || st !== S_IDLE)
            begin errors++; $display("FAIL reset_flush: flush=%0b irq=%0b cnt=%0d state=%0d expected all 0", slave_flush, irq, fault_count, st); end
        m_cnt = 8'd0; m_irq = 1'b0; m_ovf = 1'b0; m_addr = '0; m_we = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_race();
        test_timeout_read();
        test_ack_race();
        test_late_and_guard();
        test_back_to_back();
        test_saturation();
        test_reset_mid_flush();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d entries expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
